// File: rtl/axis_beam_splitter.sv
// axis_beam_splitter
//   Fans one AXI4-Stream beam of complex baseband samples out to four
//   antenna-channel streams. Each channel multiplies every sample by its own
//   complex Q1.7 weight, rounds half up and saturates to SAMPLE_WIDTH.
//   An input beat is consumed only when all four channel registers can take it.
//   New weights are captured into a pending set at any time. They move to the
//   active set only between packets, so a packet never sees a weight change.
//
// Ports
//   clock, resetn                 rising-edge clock, synchronous active-low reset
//   bWeight{0..3}_real/_imag      per-channel Q1.7 signed weight inputs
//   wgt_load                      capture all weight inputs into the pending set
//   wgt_pending                   pending set not yet applied
//   sat_clear                     clear the sticky saturation flags
//   sat_flag[3:0]                 sticky per-channel saturation flags
//   S_axis_*                      input stream (tdata/tvalid/tready/tlast)
//   M{0..3}_axis_*                per-channel output streams
module axis_beam_splitter #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [WEIGHT_WIDTH-1:0] bWeight0_real,
    input  logic [WEIGHT_WIDTH-1:0] bWeight0_imag,
    input  logic [WEIGHT_WIDTH-1:0] bWeight1_real,
    input  logic [WEIGHT_WIDTH-1:0] bWeight1_imag,
    input  logic [WEIGHT_WIDTH-1:0] bWeight2_real,
    input  logic [WEIGHT_WIDTH-1:0] bWeight2_imag,
    input  logic [WEIGHT_WIDTH-1:0] bWeight3_real,
    input  logic [WEIGHT_WIDTH-1:0] bWeight3_imag,
    input  logic                    wgt_load,
    output logic                    wgt_pending,
    input  logic                    sat_clear,
    output logic [3:0]              sat_flag,
    input  logic [DATA_WIDTH-1:0]   S_axis_tdata,
    input  logic                    S_axis_tvalid,
    output logic                    S_axis_tready,
    input  logic                    S_axis_tlast,
    output logic [DATA_WIDTH-1:0]   M0_axis_tdata,
    output logic                    M0_axis_tvalid,
    input  logic                    M0_axis_tready,
    output logic                    M0_axis_tlast,
    output logic [DATA_WIDTH-1:0]   M1_axis_tdata,
    output logic                    M1_axis_tvalid,
    input  logic                    M1_axis_tready,
    output logic                    M1_axis_tlast,
    output logic [DATA_WIDTH-1:0]   M2_axis_tdata,
    output logic                    M2_axis_tvalid,
    input  logic                    M2_axis_tready,
    output logic                    M2_axis_tlast,
    output logic [DATA_WIDTH-1:0]   M3_axis_tdata,
    output logic                    M3_axis_tvalid,
    input  logic                    M3_axis_tready,
    output logic                    M3_axis_tlast
);

    localparam int NCH    = 4;
    localparam int CPLX_W = 2 * SAMPLE_WIDTH;
    localparam int NS     = DATA_WIDTH / CPLX_W;
    localparam int PROD_W = SAMPLE_WIDTH + WEIGHT_WIDTH;
    localparam int SUM_W  = PROD_W + 1;
    localparam int FRAC   = WEIGHT_WIDTH - 1;

    localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) << (FRAC - 1);
    localparam logic signed [SUM_W-1:0] SMAX = {{(SUM_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SMIN = ~SMAX;
    localparam logic [WEIGHT_WIDTH-1:0] W_ONE = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};

    logic signed [WEIGHT_WIDTH-1:0] w_re_in  [NCH];
    logic signed [WEIGHT_WIDTH-1:0] w_im_in  [NCH];
    logic signed [WEIGHT_WIDTH-1:0] act_re   [NCH];
    logic signed [WEIGHT_WIDTH-1:0] act_im   [NCH];
    logic signed [WEIGHT_WIDTH-1:0] pend_re  [NCH];
    logic signed [WEIGHT_WIDTH-1:0] pend_im  [NCH];
    logic        [DATA_WIDTH-1:0]   data_q   [NCH];
    logic        [DATA_WIDTH-1:0]   data_d   [NCH];
    logic        [NCH-1:0]          v;
    logic        [NCH-1:0]          last_q;
    logic        [NCH-1:0]          m_ready;
    logic        [NCH-1:0]          clip;
    logic                           in_pkt;
    logic                           pending;
    logic                           accept;
    logic                           apply;

    assign w_re_in[0] = bWeight0_real;
    assign w_im_in[0] = bWeight0_imag;
    assign w_re_in[1] = bWeight1_real;
    assign w_im_in[1] = bWeight1_imag;
    assign w_re_in[2] = bWeight2_real;
    assign w_im_in[2] = bWeight2_imag;
    assign w_re_in[3] = bWeight3_real;
    assign w_im_in[3] = bWeight3_imag;

    assign m_ready = {M3_axis_tready, M2_axis_tready, M1_axis_tready, M0_axis_tready};

    // A channel can take a new beat when it is empty or draining this cycle.
    assign S_axis_tready = &(~v | m_ready);
    assign accept        = S_axis_tvalid & S_axis_tready;
    // Never swap weights on a cycle that also consumes a beat, so the
    // accepted beat and the rest of its packet keep the old set.
    assign apply         = pending & ~in_pkt & ~accept;
    assign wgt_pending   = pending;

    // Round half up, then clamp; MSB of the result flags clipping.
    function automatic logic [SAMPLE_WIDTH:0] round_sat(input logic signed [SUM_W-1:0] acc);
        logic signed [SUM_W-1:0] r;
        r = (acc + HALF) >>> FRAC;
        if (r > SMAX)      return {1'b1, SMAX[SAMPLE_WIDTH-1:0]};
        else if (r < SMIN) return {1'b1, SMIN[SAMPLE_WIDTH-1:0]};
        else               return {1'b0, r[SAMPLE_WIDTH-1:0]};
    endfunction

    // One complex sample times one complex weight; returns {clip, Q, I}.
    function automatic logic [CPLX_W:0] weigh(input logic [CPLX_W-1:0] smp,
                                              input logic signed [WEIGHT_WIDTH-1:0] wr,
                                              input logic signed [WEIGHT_WIDTH-1:0] wi);
        logic signed [SAMPLE_WIDTH-1:0] si;
        logic signed [SAMPLE_WIDTH-1:0] sq;
        logic signed [PROD_W-1:0]       p_ir;
        logic signed [PROD_W-1:0]       p_qi;
        logic signed [PROD_W-1:0]       p_ii;
        logic signed [PROD_W-1:0]       p_qr;
        logic signed [SUM_W-1:0]        s_i;
        logic signed [SUM_W-1:0]        s_q;
        logic        [SAMPLE_WIDTH:0]   ri;
        logic        [SAMPLE_WIDTH:0]   rq;
        si   = smp[SAMPLE_WIDTH-1:0];
        sq   = smp[CPLX_W-1:SAMPLE_WIDTH];
        p_ir = PROD_W'(si) * PROD_W'(wr);
        p_qi = PROD_W'(sq) * PROD_W'(wi);
        p_ii = PROD_W'(si) * PROD_W'(wi);
        p_qr = PROD_W'(sq) * PROD_W'(wr);
        s_i  = SUM_W'(p_ir) - SUM_W'(p_qi);
        s_q  = SUM_W'(p_ii) + SUM_W'(p_qr);
        ri   = round_sat(s_i);
        rq   = round_sat(s_q);
        return {ri[SAMPLE_WIDTH] | rq[SAMPLE_WIDTH], rq[SAMPLE_WIDTH-1:0], ri[SAMPLE_WIDTH-1:0]};
    endfunction

    always_comb begin : weigh_blk
        logic [CPLX_W:0] res;
        res = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            data_d[k] = '0;
            clip[k]   = 1'b0;
            for (int unsigned s = 0; s < NS; s++) begin
                res = weigh(S_axis_tdata[s*CPLX_W +: CPLX_W], act_re[k], act_im[k]);
                data_d[k][s*CPLX_W +: CPLX_W] = res[CPLX_W-1:0];
                clip[k] = clip[k] | res[CPLX_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            v        <= '0;
            last_q   <= '0;
            in_pkt   <= 1'b0;
            pending  <= 1'b0;
            sat_flag <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                data_q[k]  <= '0;
                act_re[k]  <= W_ONE;
                act_im[k]  <= '0;
                pend_re[k] <= '0;
                pend_im[k] <= '0;
            end
        end else begin
            if (accept) begin
                v      <= '1;
                last_q <= {NCH{S_axis_tlast}};
                in_pkt <= ~S_axis_tlast;
                for (int unsigned k = 0; k < NCH; k++) begin
                    data_q[k] <= data_d[k];
                end
            end else begin
                v <= v & ~m_ready;
            end

            // A new clip on an accepting cycle wins over sat_clear.
            sat_flag <= (sat_clear ? '0 : sat_flag) | (accept ? clip : '0);

            if (apply) begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    act_re[k] <= pend_re[k];
                    act_im[k] <= pend_im[k];
                end
            end

            // A load on an apply cycle refills the pending set and keeps it pending.
            if (wgt_load) begin
                pending <= 1'b1;
                for (int unsigned k = 0; k < NCH; k++) begin
                    pend_re[k] <= w_re_in[k];
                    pend_im[k] <= w_im_in[k];
                end
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    assign M0_axis_tdata  = data_q[0];
    assign M1_axis_tdata  = data_q[1];
    assign M2_axis_tdata  = data_q[2];
    assign M3_axis_tdata  = data_q[3];
    assign M0_axis_tvalid = v[0];
    assign M1_axis_tvalid = v[1];
    assign M2_axis_tvalid = v[2];
    assign M3_axis_tvalid = v[3];
    assign M0_axis_tlast  = last_q[0];
    assign M1_axis_tlast  = last_q[1];
    assign M2_axis_tlast  = last_q[2];
    assign M3_axis_tlast  = last_q[3];

endmodule
